// File: rtl/nexys_starship_pkg.sv
// Shared types, constants and helpers for the Nexys Starship game controller.
package nexys_starship_pkg;

  localparam logic [2:0] INIT = 3'b001;
  localparam logic [2:0] PLAY = 3'b010;
  localparam logic [2:0] DONE = 3'b100;

  localparam int unsigned NUM_MONSTERS = 4;
  localparam int unsigned BCD_DIGIT_W  = 4;
  localparam int unsigned BCD_DIGITS   = 4;
  localparam int unsigned SCORE_W      = BCD_DIGIT_W * BCD_DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  typedef enum logic [2:0] {
    ST_INIT = INIT,
    ST_PLAY = PLAY,
    ST_DONE = DONE
  } state_e;

  function automatic logic [2:0] popcount(input logic [NUM_MONSTERS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_MONSTERS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/nexys_starship_game_ctrl_if.sv
// Link between the game controller and the four monster terminals.
interface nexys_starship_game_ctrl_if;
  import nexys_starship_pkg::*;

  logic [NUM_MONSTERS-1:0] monster;
  logic [NUM_MONSTERS-1:0] gameover_in;
  logic                    play_flag;
  logic                    gameover_ctrl;

  modport master (
    input  monster,
    input  gameover_in,
    output play_flag,
    output gameover_ctrl
  );

  modport slave (
    output monster,
    output gameover_in,
    input  play_flag,
    input  gameover_ctrl
  );
endinterface

// File: rtl/nexys_starship_bcd_add.sv
// Combinational 4-digit BCD add of a small increment, saturating at SCORE_MAX.
module nexys_starship_bcd_add
  import nexys_starship_pkg::*;
(
  input  logic [SCORE_W-1:0] bcd_in,
  input  logic [2:0]         inc,
  output logic [SCORE_W-1:0] sum,
  output logic               carry_o
);

  logic [SCORE_W-1:0]     raw;
  logic [BCD_DIGIT_W:0]   dsum;
  logic [BCD_DIGIT_W:0]   dadj;
  logic [BCD_DIGIT_W-1:0] c;

  always_comb begin
    raw  = '0;
    dsum = '0;
    dadj = '0;
    c    = {1'b0, inc};
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      dsum = {1'b0, bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]} + {1'b0, c};
      if (dsum > 5'd9) begin
        dadj = dsum - 5'd10;
        raw[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dadj[BCD_DIGIT_W-1:0];
        c = 4'd1;
      end else begin
        raw[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dsum[BCD_DIGIT_W-1:0];
        c = '0;
      end
    end
    carry_o = c[0];
    sum     = carry_o ? SCORE_MAX : raw;
  end

endmodule

// File: rtl/nexys_starship_game_ctrl.sv
// Nexys Starship game controller: INIT/PLAY/DONE sequencing, kill scoring, high score.
module nexys_starship_game_ctrl
  import nexys_starship_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start_btn,
  nexys_starship_game_ctrl_if.master term,
  output logic [SCORE_W-1:0]   score_bcd,
  output logic [SCORE_W-1:0]   high_score_bcd,
  output logic                 q_Init,
  output logic                 q_Play,
  output logic                 q_Done
);

  state_e                  state_q, state_d;
  logic [NUM_MONSTERS-1:0] monster_prev_q, monster_prev_d;
  logic [2:0]              kill_cnt_q, kill_cnt_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [SCORE_W-1:0]      high_score_q, high_score_d;

  logic [NUM_MONSTERS-1:0] kills;
  logic [SCORE_W-1:0]      add_sum;
  logic                    add_carry;

  nexys_starship_bcd_add u_bcd_add (
    .bcd_in  (score_q),
    .inc     (kill_cnt_q),
    .sum     (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (start_btn)         state_d = ST_PLAY;
      ST_PLAY: if (|term.gameover_in) state_d = ST_DONE;
      ST_DONE: if (start_btn)         state_d = ST_INIT;
      default:                        state_d = ST_INIT;
    endcase
  end

  // Kills are qualified at capture time, so falls caused by terminals
  // resetting after gameover never reach the adder.
  always_comb begin
    monster_prev_d = term.monster;
    kills          = monster_prev_q & ~term.monster;
    kill_cnt_d     = '0;
    if (state_q == ST_PLAY && term.gameover_in == '0) begin
      kill_cnt_d = popcount(kills);
    end
  end

  // High score compares against the score as it stands after the DONE-entry
  // edge, so a kill still in flight on that edge is credited.
  always_comb begin
    score_d      = score_q;
    high_score_d = high_score_q;
    if (state_q == ST_INIT && start_btn) begin
      score_d = '0;
    end else if (kill_cnt_q != '0) begin
      score_d = add_carry ? SCORE_MAX : add_sum;
    end
    if (state_q == ST_PLAY && state_d == ST_DONE && score_d > high_score_q) begin
      high_score_d = score_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_INIT;
      monster_prev_q <= '0;
      kill_cnt_q     <= '0;
      score_q        <= '0;
      high_score_q   <= '0;
    end else begin
      state_q        <= state_d;
      monster_prev_q <= monster_prev_d;
      kill_cnt_q     <= kill_cnt_d;
      score_q        <= score_d;
      high_score_q   <= high_score_d;
    end
  end

  assign q_Init             = (state_q == ST_INIT);
  assign q_Play             = (state_q == ST_PLAY);
  assign q_Done             = (state_q == ST_DONE);
  assign term.play_flag     = q_Play;
  assign term.gameover_ctrl = q_Done;
  assign score_bcd          = score_q;
  assign high_score_bcd     = high_score_q;

endmodule

// File: doc/nexys_starship_game_ctrl.md
# nexys_starship_game_ctrl

Central game controller for Nexys Starship. It sits downstream of the four monster terminals (top, bottom, left, right): it consumes their monster-present and gameover flags, and it drives the shared `play_flag` and `gameover_ctrl` lines back into them. It counts cleared monsters into a saturating 4-digit BCD score, keeps a session high score, and sequences the game through INIT, PLAY and DONE on the debounced start button.

## Interface
- `NUM_MONSTERS`, 4: number of monster terminals; bit order is {right, left, bottom, top}.
- `SCORE_MAX`, 16'h9999: BCD saturation value of the score.
- `Clk`  in  1: system clock; the only clock.
- `Reset`  in  1: synchronous, active-high.
- `start_btn`  in  1: single-cycle debounced start pulse.
- `monster`  in  NUM_MONSTERS: per-terminal monster-present level.
- `gameover_in`  in  NUM_MONSTERS: per-terminal gameover level.
- `play_flag`  out  1: high while in PLAY.
- `gameover_ctrl`  out  1: high while in DONE.
- `score_bcd`  out  16: current score, 4 BCD digits.
- `high_score_bcd`  out  16: best score since Reset.
- `q_Init`, `q_Play`, `q_Done`  out  1 each: one-hot state flags.

## Operation
- Reset values:
  - state = INIT, so `q_Init` = 1 and the other two flags = 0.
  - `play_flag` = 0, `gameover_ctrl` = 0.
  - `score_bcd` = 0, `high_score_bcd` = 0.
  - Edge-detect register `monster_d` = 0.
- INIT
  - `start_btn` → PLAY, and `score_bcd` clears to 0 on the same edge.
  - `gameover_in` is ignored.
- PLAY
  - Any `gameover_in` bit high → DONE. `gameover_in` takes priority over `start_btn`.
  - `start_btn` is ignored.
- DONE
  - `start_btn` → INIT.
  - `high_score_bcd` loads `score_bcd` on the DONE-entry edge if `score_bcd` is greater (unsigned BCD compare).
- Kill detection
  - A kill is `monster_d[i] & ~monster[i]`.
  - Kills count only in PLAY, and only on cycles where `gameover_in` == 0. Falling edges caused by terminals resetting after gameover must not score.
  - Simultaneous kills each count; up to 4 per cycle.
- Score arithmetic
  - `score_bcd` += popcount(kills), a value 0..4, using a BCD add with decimal carry across digits.
  - Saturates at 16'h9999 and never wraps.
- `monster_d` updates every cycle in every state.
- Illegal state encoding → INIT on the next edge.
- `Reset` mid-game returns every output to its reset value on the next edge, including `high_score_bcd`.

## Timing
- All outputs are registered, with a 1-cycle latency from input to output.
- `start_btn` at edge N → `play_flag` = 1 after edge N; `score_bcd` = 0 after edge N.
- `gameover_in` high at edge N → `play_flag` = 0 and `gameover_ctrl` = 1 after edge N; `high_score_bcd` updates after edge N.
- A kill seen at edge N (falling edge between N−1 and N) → `score_bcd` updated after edge N+1.
  - The registered edge detect plus the registered add give 2 edges total.
- `start_btn` held high for multiple cycles: each cycle is treated as a pulse. DONE → INIT → PLAY therefore takes 2 consecutive cycles.
- `gameover_ctrl` is held for the whole of DONE. Terminals stay in their INIT until `play_flag` rises again.

## Structure
- Package `nexys_starship_pkg` holds:
  - State localparams INIT = 3'b001, PLAY = 3'b010, DONE = 3'b100.
  - `NUM_MONSTERS`.
  - BCD digit width of 4 and digit count of 4.
  - `SCORE_MAX`.
- Sub-module `nexys_starship_bcd_add`: combinational, 16-bit BCD plus a 3-bit increment, with a saturate output and a carry-out flag. It is reused by the display path.
- Top-level contents:
  - FSM.
  - Kill edge detector and popcount.
  - Score register and high-score register with comparator.

## Test plan
- Reset, pulse `start_btn`, clear `monster[3]` (right) 1→0 in PLAY → `score_bcd` = 16'h0001 two edges after the fall; `play_flag` = 1.
- Score at 16'h0008, all four `monster` bits fall in the same cycle → `score_bcd` = 16'h0012.
- Score at 16'h9997, three kills in one cycle → `score_bcd` = 16'h9999 (saturated); a further kill leaves it at 16'h9999.
- In PLAY with score 16'h0005, `gameover_in[1]` = 1 in the same cycle `monster[0]` falls →
  - DONE next edge; `gameover_ctrl` = 1; `play_flag` = 0.
  - `score_bcd` stays 16'h0005; `high_score_bcd` = 16'h0005.
- Second game reaches 16'h0003 then gameover → `high_score_bcd` stays 16'h0005. Kills during DONE and INIT do not change `score_bcd`.
- Assert `Reset` mid-PLAY with score 16'h0042 → after the next edge `q_Init` = 1, and `score_bcd`, `high_score_bcd`, `play_flag` and `gameover_ctrl` are all 0.
